// File: rtl/system_0_sysid_ext.sv
// Avalon-MM system-ID slave: build identity words, scratch register and a
// 64-bit uptime counter whose high word is snapshotted on low-word reads.
module system_0_sysid_ext #(
    parameter logic [31:0] SYS_ID        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h6688_7A78,
    parameter logic [31:0] VERSION       = 32'h0001_0000,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
    parameter int unsigned ADDR_W        = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 64;

    localparam logic [31:0] A_ID        = 32'd0;
    localparam logic [31:0] A_TIMESTAMP = 32'd1;
    localparam logic [31:0] A_VERSION   = 32'd2;
    localparam logic [31:0] A_SCRATCH   = 32'd3;
    localparam logic [31:0] A_UP_LO     = 32'd4;
    localparam logic [31:0] A_UP_HI     = 32'd5;
    localparam logic [31:0] A_CTRL      = 32'd6;

    logic [31:0]       word_c;
    logic [DATA_W-1:0] scratch;
    logic [CNT_W-1:0]  uptime;
    logic [31:0]       shadow;
    logic              freeze;
    logic [DATA_W-1:0] rdata_c;
    logic              wr_ctrl_c;
    logic              clear_c;
    logic              rd_lo_c;

    assign word_c    = 32'(address);
    assign wr_ctrl_c = write && (word_c == A_CTRL) && byteenable[0];
    assign clear_c   = wr_ctrl_c && writedata[0];
    assign rd_lo_c   = read && (word_c == A_UP_LO);

    // Read mux sees pre-edge state, so a same-cycle write returns the old value
    always_comb begin
        rdata_c = '0;
        case (word_c)
            A_ID:        rdata_c = SYS_ID;
            A_TIMESTAMP: rdata_c = TIMESTAMP;
            A_VERSION:   rdata_c = VERSION;
            A_SCRATCH:   rdata_c = scratch;
            A_UP_LO:     rdata_c = uptime[31:0];
            A_UP_HI:     rdata_c = shadow;
            A_CTRL:      rdata_c = {30'b0, freeze, 1'b0};
            default:     rdata_c = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rdata_c;
            end
        end
    end

    // Scratch: per-byte-lane write
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= SCRATCH_RESET;
        end else if (write && (word_c == A_SCRATCH)) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freeze <= 1'b0;
        end else if (wr_ctrl_c) begin
            freeze <= writedata[1];
        end
    end

    // Uptime: CLEAR beats FREEZE beats increment; hold is an explicit self-load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uptime <= '0;
        end else if (clear_c) begin
            uptime <= '0;
        end else if (freeze) begin
            uptime <= uptime;
        end else begin
            uptime <= uptime + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (rd_lo_c) begin
            shadow <= uptime[63:32];
        end
    end

endmodule
